uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single UART transmitter between N byte-stream requesters.
- Accepts bytes over per-requester valid/ready handshakes and drives the transmitter's `send`/`data` inputs. The transmitter has no busy output, so the block paces frames with an internal frame timer.
- Supports multi-byte packet lock via `req_last`, so one requester's packet is never interleaved with another's.
- Sits between the command/response logic and `tx`.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- FRAME_CYCLES, 160, clk cycles reserved per frame after each send pulse; must be >= 146 (16 clk/bit, 9 bit slots, plus return to IDLE).
- LOCK_TIMEOUT, 1024, cycles to wait for the next byte of a locked packet before releasing the lock; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester byte valid
- req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  N_REQ  accepted byte ends the packet; 0 keeps the grant locked to this requester
- req_ready  out  N_REQ  one-hot accept strobe
- tx_send  out  1  one-cycle send pulse to the transmitter
- tx_data  out  8  byte to the transmitter; held stable from the send pulse until the next accept
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(N_REQ)  index of the current/last granted requester
- lock_drop  out  1  one-cycle pulse when a lock is released by timeout

Behaviour:
- Reset values: req_ready=0, tx_send=0, tx_data=0, busy=1, grant_id=0, lock_drop=0, rr_ptr=0, state=HOLD, counter=0.
- HOLD:
  - Entered on reset, because the transmitter has no reset and may be mid-frame.
  - Counts FRAME_CYCLES cycles, then goes to IDLE. No grants are issued in HOLD.
- IDLE:
  - Winner is the first set `req_valid` bit found searching from rr_ptr upward, with wrap-around.
  - `req_ready[winner]` is asserted combinationally in the same cycle; this is the accept at cycle T.
  - At T+1: tx_send=1, tx_data=byte, grant_id=winner, state=FRAME, counter=0, locked=!req_last[winner].
  - With no valid requester, the block stays in IDLE with busy=0.
- FRAME:
  - tx_send is high only in the first FRAME cycle.
  - Counter increments each cycle. When counter==FRAME_CYCLES-1, the next state is LOCK if locked, otherwise IDLE with rr_ptr=grant_id+1 (mod N_REQ).
  - Earliest next accept is T+1+FRAME_CYCLES; earliest next send is T+2+FRAME_CYCLES.
- LOCK:
  - Only `req_valid[grant_id]` is considered; req_ready goes only to grant_id, with the same accept→FRAME timing as IDLE.
  - A wait counter starts at 0 on LOCK entry.
  - If LOCK_TIMEOUT!=0 and the counter reaches LOCK_TIMEOUT-1 with no accept: pulse lock_drop, clear locked, set rr_ptr=grant_id+1, go to IDLE.
  - An accept in the same cycle as the timeout wins: no lock_drop.
- req_ready:
  - At most one bit is high, and only in IDLE/LOCK.
  - It never depends on `req_valid` of a non-winning requester.
- Valid dropped before accept: no accept, no side effects.
- Reset mid-FRAME or mid-LOCK: state→HOLD and the lock is cleared; a byte already pulsed is not resent.
- Width rules:
  - Counters are sized to $clog2(max(FRAME_CYCLES, LOCK_TIMEOUT)+1) bits.
  - rr_ptr wraps modulo N_REQ; for non-power-of-2 N_REQ, the wrap is explicit.
- The rr_ptr update is applied only at packet end, or at timeout release.

Decomposition:
- Package uart_pkg:
  - sched_state_t enum {HOLD, IDLE, FRAME, LOCK}.
  - Constants BAUD_DIV=16 and FRAME_BITS=9.
  - MIN_FRAME_CYCLES=146, used in an elaboration-time assertion on FRAME_CYCLES.
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, idx.

Test Plan:
- Reset then hold: assert rst 2 cycles, req_valid=4'b0001 from the cycle after reset.
  - req_ready[0] stays 0 for 160 cycles after rst release, then pulses.
  - tx_send pulses one cycle later.
- Round-robin: all four valid, req_last=1, data 0x10/0x21/0x32/0x43.
  - Sends in order 0x10, 0x21, 0x32, 0x43.
  - Send pulses exactly FRAME_CYCLES+1 = 161 cycles apart; grant_id sequence is 0, 1, 2, 3.
- Packet lock: req 2 sends 3 bytes 0xA0, 0xA1, 0xA2 (last on the third) while req 0 is continuously valid.
  - All three req-2 bytes go out back-to-back before any req-0 byte; next grant_id=0.
- Lock timeout: req 1 sends 0x55 with last=0, then deasserts valid.
  - lock_drop pulses 1024 cycles after LOCK entry.
  - Req 3, valid throughout, is granted the next cycle in IDLE.
- Reset mid-frame: rst asserted 50 cycles after a send pulse.
  - tx_send is not repeated for that byte.
  - The next grant occurs only after the 160-cycle HOLD.
- Wrap-around: rr_ptr=3 after a grant to req 2; only req 0 and req 1 valid.
  - Req 0 is granted first, then req 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    HOLD,
    IDLE,
    FRAME,
    LOCK
  } sched_state_t;

  localparam int BAUD_DIV = 16;
  localparam int FRAME_BITS = 9;
  localparam int MIN_FRAME_CYCLES =
    BAUD_DIV * FRAME_BITS + 2;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Rotate-priority encoder: first set request at or above ptr,
// wrapping modulo N.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW:0] pos;

  // Walk from farthest to nearest so the closest hit is kept.
  always_comb begin
    any = |req;
    idx = '0;
    pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N))
        pos = pos - (IW+1)'(N);
      if (req[pos[IW-1:0]])
        idx = pos[IW-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between
// N byte-stream requesters, with packet lock and frame pacing.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 160,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_send,
  output logic [7:0]                 tx_data,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       lock_drop
);

  localparam int IW = $clog2(N_REQ);
  localparam int CMAX =
    (FRAME_CYCLES > LOCK_TIMEOUT) ?
    FRAME_CYCLES : LOCK_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] FRAME_END =
    CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_END =
    CW'(LOCK_TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  if (FRAME_CYCLES < MIN_FRAME_CYCLES) begin : g_bad_frame
    $error("FRAME_CYCLES shorter than one UART frame");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("N_REQ must be in 2..8");
  end

  sched_state_t  state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          locked, locked_d;
  logic [IW-1:0] rr_ptr, rr_d;
  logic          send_d, drop_d;
  logic [7:0]    data_d;
  logic [IW-1:0] gid_d, next_ptr;

  logic [N_REQ-1:0] pick_req;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic             accept;

  // While locked only the owner of the packet may compete.
  always_comb begin
    pick_req = req_valid;
    if (state == LOCK)
      pick_req = req_valid & (ONE << grant_id);
  end

  rr_pick #(.N(N_REQ)) u_pick (
    .req (pick_req),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign accept = pick_any &&
    (state == IDLE || state == LOCK);
  assign req_ready = accept ? (ONE << pick_idx) : '0;
  assign busy = (state != IDLE);
  assign next_ptr = (grant_id == IW'(N_REQ - 1)) ?
    '0 : grant_id + 1'b1;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    locked_d = locked;
    rr_d     = rr_ptr;
    send_d   = 1'b0;
    data_d   = tx_data;
    gid_d    = grant_id;
    drop_d   = 1'b0;
    unique case (state)
      HOLD: begin
        if (cnt == FRAME_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      IDLE, LOCK: begin
        if (accept) begin
          state_d  = FRAME;
          cnt_d    = '0;
          send_d   = 1'b1;
          data_d   = req_data[{pick_idx, 3'b000} +: 8];
          gid_d    = pick_idx;
          locked_d = !req_last[pick_idx];
        end else if (state == LOCK) begin
          if (LOCK_TIMEOUT != 0 && cnt == LOCK_END) begin
            state_d  = IDLE;
            cnt_d    = '0;
            locked_d = 1'b0;
            rr_d     = next_ptr;
            drop_d   = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      FRAME: begin
        if (cnt == FRAME_END) begin
          cnt_d = '0;
          if (locked) begin
            state_d = LOCK;
          end else begin
            state_d = IDLE;
            rr_d    = next_ptr;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      locked    <= 1'b0;
      rr_ptr    <= '0;
      tx_send   <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      lock_drop <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      locked    <= locked_d;
      rr_ptr    <= rr_d;
      tx_send   <= send_d;
      tx_data   <= data_d;
      grant_id  <= gid_d;
      lock_drop <= drop_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed scenarios plus random packet traffic checked against
// a packet-level round-robin model of the scheduler.
module tb_uart_tx_sched;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } item_t;

  typedef struct packed {
    int         cyc;
    logic [7:0] data;
    logic [1:0] gid;
  } send_t;

  typedef struct packed {
    int cyc;
    int idx;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;
  logic        lock_drop;

  int cyc = 0;
  int rel = 0;
  int checks = 0;
  int errors = 0;
  int budget = 3000;
  logic [3:0] acc_s = '0;

  item_t rq[4][$];
  item_t mq[4][$];
  send_t send_q[$];
  acc_t  acc_q[$];
  int    drop_q[$];
  send_t exp_q[$];

  uart_tx_sched #(
    .N_REQ        (4),
    .FRAME_CYCLES (160),
    .LOCK_TIMEOUT (1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id),
    .lock_drop (lock_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int i,
                      input logic [7:0] d,
                      input logic l);
    item_t it;
    it.data = d;
    it.last = l;
    rq[i].push_back(it);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) rq[i].delete();
    send_q.delete();
    acc_q.delete();
    drop_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rel = cyc;
  endtask

  task automatic get_send(output send_t s);
    bit ok;
    ok = 1'b0;
    s = '0;
    for (int i = 0; i <= budget && !ok; i++) begin
      if (send_q.size() > 0) begin
        s = send_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("send_seen", 32'(ok), 1);
    if (!ok) budget = 200;
  endtask

  task automatic get_acc(output acc_t a);
    bit ok;
    ok = 1'b0;
    a = '0;
    for (int i = 0; i <= budget && !ok; i++) begin
      if (acc_q.size() > 0) begin
        a = acc_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept_seen", 32'(ok), 1);
    if (!ok) budget = 200;
  endtask

  task automatic get_drop(output int d);
    bit ok;
    ok = 1'b0;
    d = 0;
    for (int i = 0; i <= budget && !ok; i++) begin
      if (drop_q.size() > 0) begin
        d = drop_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("drop_seen", 32'(ok), 1);
    if (!ok) budget = 200;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requesters: hold each byte until it is accepted.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc_s[i] && rq[i].size() > 0)
          void'(rq[i].pop_front());
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = rq[i][0].data;
          req_last[i]        = rq[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  initial forever begin
    send_t s;
    acc_t  a;
    @(negedge clk);
    acc_s = req_valid & req_ready;
    chk("ready_onehot", 32'($onehot0(req_ready)), 1);
    chk("ready_no_valid", 32'(req_ready & ~req_valid), 0);
    if (tx_send) begin
      s.cyc  = cyc;
      s.data = tx_data;
      s.gid  = grant_id;
      send_q.push_back(s);
    end
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        a.cyc = cyc;
        a.idx = i;
        acc_q.push_back(a);
      end
    end
    if (lock_drop) drop_q.push_back(cyc);
  end

  initial begin
    send_t s, s0, e;
    acc_t a;
    item_t it;
    int d, ptr, j, np, len, tot;
    logic [7:0] rrd [4];
    logic [7:0] lkd [4];
    rrd = '{8'h10, 8'h21, 8'h32, 8'h43};
    lkd = '{8'hA0, 8'hA1, 8'hA2, 8'h0B};

    do_reset();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_send", 32'(tx_send), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_drop", 32'(lock_drop), 0);
    push(0, 8'h5A, 1'b1);
    get_acc(a);
    chk("hold_acc_cyc", a.cyc - rel, 160);
    chk("hold_acc_idx", a.idx, 0);
    get_send(s);
    chk("hold_send_cyc", s.cyc - rel, 161);
    chk("hold_send_data", 32'(s.data), 8'h5A);
    chk("hold_send_gid", 32'(s.gid), 0);

    do_reset();
    for (int i = 0; i < 4; i++) push(i, rrd[i], 1'b1);
    for (int k = 0; k < 4; k++) begin
      get_send(s);
      chk("rr_cyc", s.cyc - rel, 161 + 161 * k);
      chk("rr_data", 32'(s.data), 32'(rrd[k]));
      chk("rr_gid", 32'(s.gid), k);
    end

    push(2, 8'hA0, 1'b0);
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b1);
    get_send(s0);
    chk("lock_first_data", 32'(s0.data), 8'hA0);
    chk("lock_first_gid", 32'(s0.gid), 2);
    push(0, 8'h0B, 1'b1);
    for (int k = 1; k < 4; k++) begin
      get_send(s);
      chk("lock_cyc", s.cyc - s0.cyc, 161 * k);
      chk("lock_data", 32'(s.data), 32'(lkd[k]));
      chk("lock_gid", 32'(s.gid), (k < 3) ? 2 : 0);
    end

    acc_q.delete();
    push(1, 8'h55, 1'b0);
    push(3, 8'h77, 1'b1);
    get_send(s0);
    chk("to_first_data", 32'(s0.data), 8'h55);
    chk("to_first_gid", 32'(s0.gid), 1);
    acc_q.delete();
    get_drop(d);
    chk("to_drop_cyc", d - s0.cyc, 1184);
    get_acc(a);
    chk("to_acc_cyc", a.cyc - s0.cyc, 1184);
    chk("to_acc_idx", a.idx, 3);
    get_send(s);
    chk("to_send_cyc", s.cyc - s0.cyc, 1185);
    chk("to_send_data", 32'(s.data), 8'h77);
    chk("to_send_gid", 32'(s.gid), 3);

    push(2, 8'hC3, 1'b1);
    get_send(s0);
    chk("mid_data", 32'(s0.data), 8'hC3);
    chk("mid_gid", 32'(s0.gid), 2);
    repeat (49) @(negedge clk);
    chk("mid_no_extra", send_q.size(), 0);
    do_reset();
    push(1, 8'hD4, 1'b1);
    get_acc(a);
    chk("mid_acc_cyc", a.cyc - rel, 160);
    chk("mid_acc_idx", a.idx, 1);
    get_send(s);
    chk("mid_send_cyc", s.cyc - rel, 161);
    chk("mid_send_data", 32'(s.data), 8'hD4);
    chk("mid_send_gid", 32'(s.gid), 1);

    push(2, 8'hE2, 1'b1);
    get_send(s0);
    chk("wrap_pre_gid", 32'(s0.gid), 2);
    push(0, 8'hE0, 1'b1);
    push(1, 8'hE1, 1'b1);
    get_send(s);
    chk("wrap_a_cyc", s.cyc - s0.cyc, 161);
    chk("wrap_a_data", 32'(s.data), 8'hE0);
    chk("wrap_a_gid", 32'(s.gid), 0);
    get_send(s);
    chk("wrap_b_cyc", s.cyc - s0.cyc, 322);
    chk("wrap_b_data", 32'(s.data), 8'hE1);
    chk("wrap_b_gid", 32'(s.gid), 1);
    repeat (170) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(req_ready), 0);
    chk("idle_data", 32'(tx_data), 8'hE1);
    chk("idle_gid", 32'(grant_id), 1);

    do_reset();
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      np = $urandom_range(2, 0);
      if (i == 0 && np == 0) np = 1;
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(3, 1);
        for (int b = 0; b < len; b++) begin
          it.data = 8'($urandom);
          it.last = (b == len - 1);
          rq[i].push_back(it);
          mq[i].push_back(it);
          tot++;
        end
      end
    end
    // Whole packets go out one at a time, owners taken in
    // round-robin order, one send every 161 cycles.
    exp_q.delete();
    ptr = 0;
    while (tot > 0) begin
      j = ptr;
      while (mq[j].size() == 0) j = (j + 1) % 4;
      do begin
        it = mq[j].pop_front();
        tot--;
        e.cyc  = rel + 161 * (exp_q.size() + 1);
        e.data = it.data;
        e.gid  = 2'(j);
        exp_q.push_back(e);
      end while (!it.last);
      ptr = (j + 1) % 4;
    end
    foreach (exp_q[k]) begin
      get_send(s);
      chk("rand_cyc", s.cyc, exp_q[k].cyc);
      chk("rand_data", 32'(s.data), 32'(exp_q[k].data));
      chk("rand_gid", 32'(s.gid), 32'(exp_q[k].gid));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
